// File: rtl/fp_add_sequencer_if.sv
// Operand/result handshake bundle for fp_add_sequencer: valid/ready on the
// operand side, valid/ready plus result and exception flags on the result side.
interface fp_add_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        inv;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, ovf, unf, inv
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, ovf, unf, inv
    );
endinterface

// File: rtl/fp_add_sequencer.sv
// Sequential IEEE-754 single-precision adder: one operation in flight, one-bit-per-cycle
// alignment and normalization on a shared 25-bit adder, truncating rounding.
module fp_add_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    fp_add_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam logic [4:0]  MAX_ALIGN = 5'd25;

    state_t      state;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        ovf_q;
    logic        unf_q;
    logic        inv_q;
    logic [31:0] result_q;
    logic [4:0]  cnt_q;

    logic        sign_q;
    logic        sub_q;
    logic [7:0]  exp_q;
    logic [23:0] mant_x_q;
    logic [23:0] mant_y_q;
    logic [22:0] sum_q;

    logic        s_a;
    logic        s_b;
    logic [7:0]  e_a;
    logic [7:0]  e_b;
    logic [22:0] m_a;
    logic [22:0] m_b;
    logic        special;
    logic        a_zero;
    logic        b_zero;
    logic        a_is_x;
    logic [7:0]  exp_diff;
    logic [4:0]  align_cnt;
    logic [24:0] add_sum;
    logic        accept;

    // Beyond 25 shifts the smaller mantissa is already all zeros.
    function automatic logic [4:0] sat_align(input logic [7:0] diff);
        return (diff > 8'd25) ? MAX_ALIGN : diff[4:0];
    endfunction

    function automatic logic [31:0] pack_fp(input logic sign, input logic [7:0] exp,
                                            input logic [22:0] frac);
        return {sign, exp, frac};
    endfunction

    function automatic logic [31:0] sat_inf(input logic sign);
        return {sign, 8'hFF, 23'd0};
    endfunction

    always_comb begin
        s_a       = bus.a[31];
        e_a       = bus.a[30:23];
        m_a       = bus.a[22:0];
        s_b       = bus.b[31];
        e_b       = bus.b[30:23];
        m_b       = bus.b[22:0];
        special   = (e_a == 8'hFF) || (e_b == 8'hFF);
        a_zero    = (e_a == 8'd0);
        b_zero    = (e_b == 8'd0);
        // Exponent-then-mantissa magnitude order is the order of the low 31 bits; ties pick a.
        a_is_x    = (bus.a[30:0] >= bus.b[30:0]);
        exp_diff  = a_is_x ? (e_a - e_b) : (e_b - e_a);
        align_cnt = sat_align(exp_diff);
        add_sum   = sub_q ? ({1'b0, mant_x_q} - {1'b0, mant_y_q})
                          : ({1'b0, mant_x_q} + {1'b0, mant_y_q});
    end

    assign accept        = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
    assign bus.inv       = inv_q;

    // Control: state, handshakes, packed result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
            cnt_q       <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        ovf_q      <= 1'b0;
                        unf_q      <= 1'b0;
                        inv_q      <= 1'b0;
                        state      <= DONE;
                        if (special) begin
                            result_q <= QNAN;
                            inv_q    <= 1'b1;
                        end else if (a_zero && b_zero) begin
                            result_q <= {s_a & s_b, 31'd0};
                        end else if (a_zero) begin
                            result_q <= bus.b;
                        end else if (b_zero) begin
                            result_q <= bus.a;
                        end else begin
                            cnt_q <= align_cnt;
                            state <= (align_cnt != 5'd0) ? ALIGN : ADD;
                        end
                    end
                end
                ALIGN: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) state <= ADD;
                end
                ADD: begin
                    state <= DONE;
                    if (add_sum == 25'd0) begin
                        result_q <= 32'd0;
                    end else if (add_sum[24]) begin
                        if (exp_q == 8'd254) begin
                            result_q <= sat_inf(sign_q);
                            ovf_q    <= 1'b1;
                        end else begin
                            result_q <= pack_fp(sign_q, exp_q + 8'd1, add_sum[23:1]);
                        end
                    end else if (add_sum[23]) begin
                        result_q <= pack_fp(sign_q, exp_q, add_sum[22:0]);
                    end else begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    // sum_q holds bits [22:0]; bit 23 is known zero while in NORM.
                    if (exp_q == 8'd1) begin
                        result_q <= 32'd0;
                        unf_q    <= 1'b1;
                        state    <= DONE;
                    end else if (sum_q[22]) begin
                        result_q <= pack_fp(sign_q, exp_q - 8'd1, {sum_q[21:0], 1'b0});
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operands, shared shifter and adder; only meaningful while state is busy.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    sign_q   <= a_is_x ? s_a : s_b;
                    exp_q    <= a_is_x ? e_a : e_b;
                    mant_x_q <= a_is_x ? {1'b1, m_a} : {1'b1, m_b};
                    mant_y_q <= a_is_x ? {1'b1, m_b} : {1'b1, m_a};
                    sub_q    <= s_a ^ s_b;
                end
            end
            ALIGN: mant_y_q <= mant_y_q >> 1;
            ADD:   sum_q <= add_sum[22:0];
            NORM: begin
                sum_q <= sum_q << 1;
                exp_q <= exp_q - 8'd1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: directed corner vectors, randomized operations against
// an arithmetic reference model, backpressure and mid-operation reset.
module tb_fp_add_sequencer;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fp_add_sequencer_if bus ();

    fp_add_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    // Reference: exact integer arithmetic on the significands; flags are {ovf, unf, inv}.
    // lat < 0 means latency is not checked.
    function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [2:0] fl,
                                    output int lat);
        logic [31:0] x;
        logic [31:0] y;
        longint      mx;
        longint      my;
        longint      s;
        int          ex;
        int          ey;
        int          sh;
        int          lz;
        fl  = 3'b000;
        r   = 32'd0;
        lat = 1;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            r  = 32'h7FC00000;
            fl = 3'b001;
            return;
        end
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
            r = {a[31] & b[31], 31'd0};
            return;
        end
        if (a[30:23] == 8'd0) begin r = b; return; end
        if (b[30:23] == 8'd0) begin r = a; return; end
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex  = int'(x[30:23]);
        ey  = int'(y[30:23]);
        sh  = (ex - ey > 25) ? 25 : ex - ey;
        mx  = longint'({1'b1, x[22:0]});
        my  = longint'({1'b1, y[22:0]}) >> sh;
        s   = (x[31] == y[31]) ? mx + my : mx - my;
        lat = 2 + sh;
        if (s == 0) begin
            r = 32'd0;
        end else if (s >= 16777216) begin
            if (ex == 254) begin
                r  = {x[31], 8'hFF, 23'd0};
                fl = 3'b100;
            end else begin
                s = s / 2;
                r = {x[31], 8'(ex + 1), s[22:0]};
            end
        end else begin
            lz = 0;
            while (s < 8388608) begin
                s  = s * 2;
                lz = lz + 1;
            end
            if (lz > ex - 1) begin
                r   = 32'd0;
                fl  = 3'b010;
                lat = -1;
            end else begin
                r   = {x[31], 8'(ex - lz), s[22:0]};
                lat = 2 + sh + lz;
            end
        end
    endfunction

    // Runs one operation starting at a negedge; ends at the negedge after the handshake.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] r, output logic [2:0] fl, output int lat,
                         output int wt, output bit busy, output bit post, output bit tmo);
        tmo  = 1'b0;
        busy = 1'b0;
        post = 1'b0;
        lat  = 0;
        wt   = 0;
        r    = 32'd0;
        fl   = 3'b000;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        while (!bus.in_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        if (wt >= 100) begin
            tmo = 1'b1;
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Garbage on a/b with in_valid held high must be ignored while busy.
        bus.a = $urandom;
        bus.b = $urandom;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) tmo = 1'b1;
        r    = bus.result;
        fl   = {bus.ovf, bus.unf, bus.inv};
        busy = bus.in_ready;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        post = bus.in_ready && !bus.out_valid;
    endtask

    task automatic gen_pair(output logic [31:0] av, output logic [31:0] bv);
        int mode;
        int ea;
        int eb;
        logic [31:0] t;
        mode = int'($urandom_range(0, 5));
        av   = $urandom;
        bv   = $urandom;
        ea   = int'(av[30:23]);
        eb   = int'(bv[30:23]);
        case (mode)
            1: begin
                ea = int'($urandom_range(1, 254));
                eb = ea + int'($urandom_range(0, 6)) - 3;
                if (eb < 1) eb = 1;
                if (eb > 254) eb = 254;
            end
            2: begin
                ea = int'($urandom_range(1, 254));
                eb = ea;
                bv[31]   = ~av[31];
                bv[22:8] = av[22:8];
            end
            3: begin
                ea = int'($urandom_range(1, 4));
                eb = int'($urandom_range(1, 4));
                bv[31]   = ~av[31];
                bv[22:4] = av[22:4];
            end
            4: begin
                ea = int'($urandom_range(1, 254));
                eb = 0;
            end
            5: begin
                ea = int'($urandom_range(250, 254));
                eb = int'($urandom_range(250, 254));
                bv[31] = av[31];
            end
            default: ;
        endcase
        av[30:23] = 8'(ea);
        bv[30:23] = 8'(eb);
        if (mode == 4 && $urandom_range(0, 1) == 1) begin
            t  = av;
            av = bv;
            bv = t;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.ovf, bus.unf, bus.inv} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_hold: rdy=%b vld=%b res=%h flags=%b%b%b, want rdy=1 vld=0 res=00000000 flags=000",
                     bus.in_ready, bus.out_valid, bus.result, bus.ovf, bus.unf, bus.inv);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.in_ready, bus.out_valid, bus.result} !== {1'b1, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b vld=%b res=%h, want rdy=1 vld=0 res=00000000",
                     bus.in_ready, bus.out_valid, bus.result);
        end
    endtask

    task automatic test_directed();
        vec_t        v [14];
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
        int          wt;
        bit          busy;
        bit          post;
        bit          tmo;
        v[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 2};
        v[1]  = '{32'h3F800000, 32'h3F000000, 32'h3FC00000, 3'b000, 3};
        v[2]  = '{32'h3FC00000, 32'hBFA00000, 32'h3E800000, 3'b000, 4};
        v[3]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000, 2};
        v[4]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000, 26};
        v[5]  = '{32'h3F800000, 32'h00000001, 32'h3F800000, 3'b000, 1};
        v[6]  = '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b001, 1};
        v[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b100, 2};
        v[8]  = '{32'h3F800000, 32'h0B800000, 32'h3F800000, 3'b000, 27};
        v[9]  = '{32'hBF800000, 32'h3F000000, 32'hBF000000, 3'b000, 4};
        v[10] = '{32'h80000000, 32'h80000001, 32'h80000000, 3'b000, 1};
        v[11] = '{32'h00800001, 32'h80800000, 32'h00000000, 3'b010, -1};
        v[12] = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 3'b000, 3};
        v[13] = '{32'hC0000000, 32'h3F800000, 32'hBF800000, 3'b000, 4};
        for (int i = 0; i < 14; i++) begin
            do_op(v[i].a, v[i].b, r, fl, lat, wt, busy, post, tmo);
            n_vec++;
            if (tmo || r !== v[i].r || fl !== v[i].fl) begin
                n_err++;
                $display("FAIL directed_%0d %h+%h: res=%h flags=%b tmo=%b, want res=%h flags=%b",
                         i, v[i].a, v[i].b, r, fl, tmo, v[i].r, v[i].fl);
            end
            if (v[i].lat >= 0) begin
                n_vec++;
                if (lat !== v[i].lat) begin
                    n_err++;
                    $display("FAIL directed_lat_%0d: L=%0d, want %0d", i, lat, v[i].lat);
                end
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] r;
        logic [31:0] er;
        logic [2:0]  fl;
        logic [2:0]  efl;
        int          lat;
        int          elat;
        int          wt;
        bit          busy;
        bit          post;
        bit          tmo;
        for (int i = 0; i < n; i++) begin
            gen_pair(av, bv);
            ref_add(av, bv, er, efl, elat);
            do_op(av, bv, r, fl, lat, wt, busy, post, tmo);
            n_vec++;
            if (tmo || r !== er || fl !== efl) begin
                n_err++;
                $display("FAIL random_%0d %h+%h: res=%h flags=%b tmo=%b, want res=%h flags=%b",
                         i, av, bv, r, fl, tmo, er, efl);
            end
            if (elat >= 0) begin
                n_vec++;
                if (lat !== elat) begin
                    n_err++;
                    $display("FAIL random_lat_%0d %h+%h: L=%0d, want %0d", i, av, bv, lat, elat);
                end
            end
            n_vec++;
            if (busy || !post) begin
                n_err++;
                $display("FAIL random_hs_%0d: in_ready_at_done=%b idle_after=%b, want 0 and 1", i, busy, post);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av [3];
        logic [31:0] er [3];
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
        int          wt;
        bit          busy;
        bit          post;
        bit          tmo;
        av[0] = 32'h40400000; er[0] = 32'h40C00000;
        av[1] = 32'h3E000000; er[1] = 32'h3E800000;
        av[2] = 32'hC1200000; er[2] = 32'hC1A00000;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], av[i], r, fl, lat, wt, busy, post, tmo);
            n_vec++;
            if (tmo || wt !== 0 || r !== er[i] || lat !== 2) begin
                n_err++;
                $display("FAIL b2b_%0d: res=%h wait=%0d L=%0d tmo=%b, want res=%h wait=0 L=2",
                         i, r, wt, lat, tmo, er[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.a        = 32'h7F7FFFFF;
        bus.b        = 32'h7F7FFFFF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t !== 2 || bus.result !== 32'h7F800000 || bus.ovf !== 1'b1) begin
            n_err++;
            $display("FAIL bp_result: L=%0d res=%h ovf=%b, want L=2 res=7f800000 ovf=1", t, bus.result, bus.ovf);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'h7F800000 || bus.ovf !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d: vld=%b res=%h ovf=%b rdy=%b, want vld=1 res=7f800000 ovf=1 rdy=0",
                         i, bus.out_valid, bus.result, bus.ovf, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: rdy=%b vld=%b, want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
        int          wt;
        bit          busy;
        bit          post;
        bit          tmo;
        bus.in_valid = 1'b1;
        bus.a        = 32'h3F800000;
        bus.b        = 32'h33800000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_busy: rdy=%b vld=%b, want rdy=0 vld=0", bus.in_ready, bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.ovf, bus.unf, bus.inv} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
            n_err++;
            $display("FAIL mid_reset: rdy=%b vld=%b res=%h flags=%b%b%b, want rdy=1 vld=0 res=00000000 flags=000",
                     bus.in_ready, bus.out_valid, bus.result, bus.ovf, bus.unf, bus.inv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h3F800000, 32'h3F800000, r, fl, lat, wt, busy, post, tmo);
        n_vec++;
        if (tmo || r !== 32'h40000000 || fl !== 3'b000 || lat !== 2) begin
            n_err++;
            $display("FAIL post_reset_op: res=%h flags=%b L=%0d tmo=%b, want res=40000000 flags=000 L=2",
                     r, fl, lat, tmo);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random(400);
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_add_sequencer.md
# fp_add_sequencer

Multi-cycle controller that sequences one IEEE-754 single-precision addition through unpack, align, add, normalize and pack stages. It shares one shifter and one 25-bit adder across all steps. It sits between an operand producer and a result consumer using valid/ready handshakes, and accepts one operation at a time. Alignment and normalization shift one bit per cycle, so latency depends on the data and is exactly predictable.

## Interface
- No parameters; the format is fixed at 32-bit single precision.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a/b present
- in_ready  out  1  high only in IDLE; transfer occurs on in_valid && in_ready
- a, b  in  32  operands (s_a/e_a/m_a = a[31]/a[30:23]/a[22:0]; same split for b)
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts on out_valid && out_ready
- result  out  32  sum a+b
- ovf, unf, inv  out  1 each  overflow, underflow and invalid flags; valid with result

## Operation
- States: IDLE, ALIGN, ADD, NORM, DONE. Reset: state=IDLE, out_valid=0, result=0, all flags=0. in_ready=(state==IDLE), so it is 1 after reset.
- IDLE accept, in order of priority:
  - If e_a==255 or e_b==255: result=32'h7FC00000, inv=1, go to DONE.
  - An input with e==0 (zero or denormal) is treated as signed zero.
  - If both inputs are zero: result={s_a&s_b,31'b0}, go to DONE.
  - If exactly one input is zero: result=the other operand, unchanged, go to DONE.
  - Otherwise: unpack the 24-bit mantissas {1,m}. X is the operand of larger magnitude: compare exponent first, then mantissa; on a full tie X=a. Y is the other operand.
  - Compute cnt=min(e_X−e_Y, 25). Go to ALIGN if cnt≠0, else go to ADD.
- ALIGN: each cycle shift mY right by 1 (shifted-out bits discarded) and decrement cnt. Leave for ADD on the edge where cnt reaches 0.
- ADD: sum[24:0] = mX+mY if s_X==s_Y, else mX−mY. Result sign is s_X and result exponent starts as e_X.
  - sum==0: result=32'h00000000, go to DONE.
  - sum[24]==1 with e_X==254: result={s_X,8'hFF,23'b0}, ovf=1, go to DONE.
  - sum[24]==1 otherwise: shift sum right 1 (truncate), exp+1, go to DONE.
  - sum[23]==1: go to DONE.
  - Otherwise: go to NORM.
- NORM: each cycle shift sum left 1 and decrement exp. Exit to DONE on the edge where the shifted sum[23]==1.
  - If exp==1 and a shift is still required: result=32'h00000000, unf=1, go to DONE.
- Rounding is truncation everywhere. The packed result is {sign, exp[7:0], sum[22:0]}.
- DONE: out_valid=1, with result and flags registered and stable.
  - On out_ready, go to IDLE and clear out_valid.
  - Flags clear on the next accept.
- rst_n low at any time, including mid-operation: immediately return to the reset values. The in-flight operation is dropped and no result is produced.

## Timing
- The accept edge is edge 0; out_valid rises after edge L.
- Normal path: L = 2 + A + N.
  - A = min(exponent difference, 25).
  - N = number of NORM shifts, i.e. leading zeros of sum[23:0] (0 if carry or normalized).
- Special, zero and fast paths: L = 1.
- in_ready=0 from edge 0 until the edge after the out_valid && out_ready handshake.
- A new operation can be accepted one cycle after the handshake, never in the same cycle.
- out_valid must not drop without a handshake. result and flags must not change while out_valid=1.
- A level on in_valid in non-IDLE states is ignored. The a/b inputs are sampled only at accept.

## Test plan
- 3F800000+3F800000 (1.0+1.0): result=40000000, all flags 0, L=2.
- 3F800000+3F000000 (1.0+0.5): result=3FC00000, L=3.
- 3FC00000+BFA00000 (1.5−1.25): result=3E800000, N=2, L=4. Also 3F800000+BF800000 (1.0−1.0): result=00000000, L=2.
- Alignment range:
  - 3F800000+33800000 (exponent difference 24): result=3F800000, L=26.
  - 3F800000+00000001 (denormal treated as zero): result=3F800000, L=1.
  - 7F800000+3F800000 (Inf operand): result=7FC00000, inv=1, L=1.
- 7F7FFFFF+7F7FFFFF (largest finite doubled): result=7F800000, ovf=1. Hold out_ready=0 for 5 cycles: out_valid and result stay stable and in_ready stays 0. Then pulse out_ready: in_ready=1 on the next cycle.
- Assert rst_n=0 during ALIGN of 3F800000+33800000: immediately out_valid=0, in_ready=1, result=0. A following 1.0+1.0 returns 40000000 with L=2.
